// File: rtl/udp_rx_packer.sv
// ---------------------------------------------------------------------------
// udp_rx_packer
// Collects the receive byte stream of the UDP stack into one wide,
// right-aligned packet vector and offers it to the application through a
// valid/ready handshake. The first byte received ends up in the most
// significant occupied byte of pkt_data, and the last byte in pkt_data[7:0].
// This matches the byte order of the transmit packing path.
//
// Ports
//   rgmii_clk            sole clock
//   rstn                 asynchronous active-low reset
//   udp_rec_data_valid   byte strobe, contiguous for one packet payload
//   udp_rec_rdata        payload byte
//   udp_rec_data_length  declared payload length, sampled on the first byte
//   pkt_valid/pkt_ready  output slot handshake
//   pkt_data             packet vector, right-aligned, zero above the length
//   pkt_length           bytes stored, min(received, MAX_BYTES)
//   pkt_trunc            packet was longer than MAX_BYTES
//   pkt_len_err          received count differs from the declared length
//   drop_cnt             packets dropped on a full slot, saturating
// ---------------------------------------------------------------------------
module udp_rx_packer #(
    parameter int MAX_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                   rgmii_clk,
    input  logic                   rstn,
    input  logic                   udp_rec_data_valid,
    input  logic [7:0]             udp_rec_rdata,
    input  logic [15:0]            udp_rec_data_length,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [MAX_BYTES*8-1:0] pkt_data,
    output logic [15:0]            pkt_length,
    output logic                   pkt_trunc,
    output logic                   pkt_len_err,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int              VW      = MAX_BYTES * 8;
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t           state;
    logic [VW-1:0]    asm_q;
    // Total bytes seen in the current packet, saturating. It keeps counting
    // past MAX_BYTES so the length check still sees the real size.
    logic [CNT_W-1:0] rx_cnt;
    logic [15:0]      exp_len;
    logic             trunc_q;

    logic             slot_free;
    logic [15:0]      stored_len;
    logic             len_mismatch;

    // The slot can take a new packet when it is empty or is being emptied now.
    assign slot_free    = !pkt_valid || pkt_ready;
    assign len_mismatch = (32'(rx_cnt) != 32'(exp_len));

    always_comb begin
        stored_len = 16'(rx_cnt);
        if (rx_cnt > CAP) begin
            stored_len = 16'(MAX_BYTES);
        end
    end

    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            asm_q       <= '0;
            rx_cnt      <= '0;
            exp_len     <= '0;
            trunc_q     <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_data    <= '0;
            pkt_length  <= '0;
            pkt_trunc   <= 1'b0;
            pkt_len_err <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            // Consumer takes the packet; a reload in DONE below overrides this.
            if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RECV: begin
                    if (udp_rec_data_valid) begin
                        if (rx_cnt < CAP) begin
                            asm_q <= {asm_q[VW-9:0], udp_rec_rdata};
                        end else begin
                            trunc_q <= 1'b1;
                        end
                        if (rx_cnt != CNT_MAX) begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (slot_free) begin
                        pkt_valid   <= 1'b1;
                        pkt_data    <= asm_q;
                        pkt_length  <= stored_len;
                        pkt_trunc   <= trunc_q;
                        pkt_len_err <= len_mismatch;
                    end else if (drop_cnt != CNT_MAX) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // First byte of a packet, from IDLE or straight out of DONE so
            // that back-to-back packets lose no byte.
            if (udp_rec_data_valid && state != RECV) begin
                asm_q   <= {{(VW-8){1'b0}}, udp_rec_rdata};
                rx_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
                exp_len <= udp_rec_data_length;
                trunc_q <= 1'b0;
                state   <= RECV;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_packer.sv
module tb_udp_rx_packer;

    logic         rgmii_clk;
    logic         rstn;
    logic         udp_rec_data_valid;
    logic [7:0]   udp_rec_rdata;
    logic [15:0]  udp_rec_data_length;
    logic         pkt_ready;

    logic         pkt_valid_b, pkt_valid_s;
    logic [8191:0] pkt_data_b;
    logic [127:0] pkt_data_s;
    logic [15:0]  pkt_length_b, pkt_length_s;
    logic         pkt_trunc_b, pkt_trunc_s;
    logic         pkt_len_err_b, pkt_len_err_s;
    logic [15:0]  drop_cnt_b, drop_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_buf [32];

    udp_rx_packer dut_big (
        .rgmii_clk           (rgmii_clk),
        .rstn                (rstn),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .pkt_valid           (pkt_valid_b),
        .pkt_ready           (pkt_ready),
        .pkt_data            (pkt_data_b),
        .pkt_length          (pkt_length_b),
        .pkt_trunc           (pkt_trunc_b),
        .pkt_len_err         (pkt_len_err_b),
        .drop_cnt            (drop_cnt_b)
    );

    udp_rx_packer #(.MAX_BYTES(16)) dut_small (
        .rgmii_clk           (rgmii_clk),
        .rstn                (rstn),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .pkt_valid           (pkt_valid_s),
        .pkt_ready           (pkt_ready),
        .pkt_data            (pkt_data_s),
        .pkt_length          (pkt_length_s),
        .pkt_trunc           (pkt_trunc_s),
        .pkt_len_err         (pkt_len_err_s),
        .drop_cnt            (drop_cnt_s)
    );

    initial rgmii_clk = 1'b0;
    always #5 rgmii_clk = ~rgmii_clk;

    typedef struct {
        int          n;
        logic [15:0] decl;
        logic [63:0] in_bytes;   // first byte in [63:56]
        logic [63:0] exp_data;   // right-aligned expectation
        logic [15:0] exp_len;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives n bytes from tx_buf[off..], one per cycle, then drops the strobe.
    task automatic send(input int n, input logic [15:0] decl, input int off);
        for (int i = 0; i < n; i++) begin
            @(negedge rgmii_clk);
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = tx_buf[off + i];
            udp_rec_data_length = (i == 0) ? decl : 16'hDEAD;
        end
        @(negedge rgmii_clk);
        udp_rec_data_valid  = 1'b0;
        udp_rec_rdata       = 8'h00;
        udp_rec_data_length = 16'h0000;
    endtask

    // Number of negedges until pkt_valid is seen, -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge rgmii_clk);
            if (pkt_valid_b) begin
                lat = k;
                break;
            end
        end
    endtask

    logic [127:0] got_data [4];
    logic [15:0]  got_len  [4];
    int           got;
    int           lat;

    initial begin
        vecs[0] = '{4, 16'd4, 64'h11223344_00000000, 64'h00000000_11223344, 16'd4, 1'b0};
        vecs[1] = '{6, 16'd8, 64'hA1A2A3A4_A5A60000, 64'h0000A1A2_A3A4A5A6, 16'd6, 1'b1};
        vecs[2] = '{1, 16'd1, 64'h5A000000_00000000, 64'h00000000_0000005A, 16'd1, 1'b0};
        vecs[3] = '{8, 16'd2, 64'h01020304_05060708, 64'h01020304_05060708, 16'd8, 1'b1};
        vecs[4] = '{2, 16'd2, 64'hFF000000_00000000, 64'h00000000_0000FF00, 16'd2, 1'b0};

        rstn                = 1'b0;
        udp_rec_data_valid  = 1'b0;
        udp_rec_rdata       = 8'h00;
        udp_rec_data_length = 16'h0000;
        pkt_ready           = 1'b0;
        repeat (3) @(negedge rgmii_clk);
        check("rst_valid", 128'(pkt_valid_b), 128'd0);
        check("rst_data", 128'(|pkt_data_b), 128'd0);
        check("rst_len", 128'(pkt_length_b), 128'd0);
        check("rst_flags", 128'({pkt_trunc_b, pkt_len_err_b}), 128'd0);
        check("rst_drop", 128'(drop_cnt_b), 128'd0);
        rstn = 1'b1;

        // Table-driven single packets, consumer always ready
        pkt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++) tx_buf[j] = vecs[i].in_bytes[63-8*j -: 8];
            send(vecs[i].n, vecs[i].decl, 0);
            wait_valid(lat);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'd2);
            check($sformatf("vec%0d_data", i), pkt_data_b[127:0], 128'(vecs[i].exp_data));
            check($sformatf("vec%0d_upper", i), 128'(|pkt_data_b[8191:128]), 128'd0);
            check($sformatf("vec%0d_len", i), 128'(pkt_length_b), 128'(vecs[i].exp_len));
            check($sformatf("vec%0d_trunc", i), 128'(pkt_trunc_b), 128'd0);
            check($sformatf("vec%0d_err", i), 128'(pkt_len_err_b), 128'(vecs[i].exp_err));
            check($sformatf("vec%0d_small_data", i), pkt_data_s, 128'(vecs[i].exp_data));
            @(negedge rgmii_clk);
            check($sformatf("vec%0d_pulse", i), 128'(pkt_valid_b), 128'd0);
        end

        // Truncation: 20 bytes into the 16-byte instance
        for (int j = 0; j < 20; j++) tx_buf[j] = 8'(j);
        send(20, 16'd20, 0);
        wait_valid(lat);
        check("trunc_lat", 128'(lat), 128'd2);
        check("trunc_s_valid", 128'(pkt_valid_s), 128'd1);
        check("trunc_s_len", 128'(pkt_length_s), 128'd16);
        check("trunc_s_data", pkt_data_s, 128'h000102030405060708090A0B0C0D0E0F);
        check("trunc_s_trunc", 128'(pkt_trunc_s), 128'd1);
        check("trunc_s_err", 128'(pkt_len_err_s), 128'd0);
        check("trunc_b_len", 128'(pkt_length_b), 128'd20);
        check("trunc_b_trunc", 128'(pkt_trunc_b), 128'd0);
        @(negedge rgmii_clk);

        // Back-to-back: A (3 bytes), one idle cycle, B (2 bytes)
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h0B; tx_buf[2] = 8'h0C;
        tx_buf[3] = 8'hB1; tx_buf[4] = 8'hB2;
        got = 0;
        fork
            begin
                send(3, 16'd3, 0);
                send(2, 16'd2, 3);
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(negedge rgmii_clk);
                    if (pkt_valid_b && got < 4) begin
                        got_data[got] = pkt_data_b[127:0];
                        got_len[got]  = pkt_length_b;
                        got++;
                    end
                end
            end
        join
        check("b2b_count", 128'(got), 128'd2);
        check("b2b_a_data", got_data[0], 128'h0A0B0C);
        check("b2b_a_len", 128'(got_len[0]), 128'd3);
        check("b2b_b_data", got_data[1], 128'hB1B2);
        check("b2b_b_len", 128'(got_len[1]), 128'd2);
        check("b2b_drop", 128'(drop_cnt_b), 128'd0);

        // Backpressure: three packets while the consumer is stalled
        pkt_ready = 1'b0;
        tx_buf[0] = 8'hC1; tx_buf[1] = 8'hC2;
        tx_buf[2] = 8'hD1; tx_buf[3] = 8'hD2;
        tx_buf[4] = 8'hE1; tx_buf[5] = 8'hE2;
        send(2, 16'd2, 0);
        repeat (2) @(negedge rgmii_clk);
        send(2, 16'd2, 2);
        check("bp_mid_data", pkt_data_b[127:0], 128'hC1C2);
        repeat (2) @(negedge rgmii_clk);
        send(2, 16'd2, 4);
        repeat (4) @(negedge rgmii_clk);
        check("bp_valid", 128'(pkt_valid_b), 128'd1);
        check("bp_data", pkt_data_b[127:0], 128'hC1C2);
        check("bp_len", 128'(pkt_length_b), 128'd2);
        check("bp_drop", 128'(drop_cnt_b), 128'd2);
        pkt_ready = 1'b1;
        @(negedge rgmii_clk);
        pkt_ready = 1'b0;
        check("bp_fall", 128'(pkt_valid_b), 128'd0);
        check("bp_drop_after", 128'(drop_cnt_b), 128'd2);
        repeat (3) @(negedge rgmii_clk);
        check("bp_stay_low", 128'(pkt_valid_b), 128'd0);

        // Reset mid-packet while a packet is held in the slot
        tx_buf[0] = 8'h77; tx_buf[1] = 8'h88;
        send(2, 16'd2, 0);
        wait_valid(lat);
        check("rst2_held", 128'(pkt_valid_b), 128'd1);
        for (int j = 0; j < 5; j++) begin
            @(negedge rgmii_clk);
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = 8'(8'h90 + j);
            udp_rec_data_length = 16'd10;
        end
        #2 rstn = 1'b0;
        #1;
        check("rst2_valid", 128'(pkt_valid_b), 128'd0);
        check("rst2_data", 128'(|pkt_data_b), 128'd0);
        check("rst2_len", 128'(pkt_length_b), 128'd0);
        check("rst2_drop", 128'(drop_cnt_b), 128'd0);
        @(negedge rgmii_clk);
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata      = 8'h00;
        rstn               = 1'b1;
        repeat (5) @(negedge rgmii_clk);
        check("rst2_no_partial", 128'(pkt_valid_b), 128'd0);
        pkt_ready = 1'b1;
        tx_buf[0] = 8'h3C; tx_buf[1] = 8'h4D;
        send(2, 16'd2, 0);
        wait_valid(lat);
        check("post_lat", 128'(lat), 128'd2);
        check("post_data", pkt_data_b[127:0], 128'h3C4D);
        check("post_len", 128'(pkt_length_b), 128'd2);
        check("post_err", 128'(pkt_len_err_b), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
